// File: rtl/kavach_pkg.sv
// Shared encodings for the Kavach response sequencer:
// FSM states, anomaly flag positions and event-log field layout.
package kavach_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONFIRM  = 3'd1,
        ST_ALERT    = 3'd2,
        ST_CONTAIN  = 3'd3,
        ST_LOCKDOWN = 3'd4,
        ST_RECOVER  = 3'd5
    } state_t;

    localparam int AV_W  = 6;
    localparam int SEV_W = 2;

    localparam int AV_IPC     = 0;
    localparam int AV_PC_JUMP = 1;
    localparam int AV_PRIV    = 2;
    localparam int AV_MEM_OOB = 3;
    localparam int AV_FLUSH   = 4;
    localparam int AV_NMI     = 5;

    localparam logic [SEV_W-1:0] SEV_NONE = 2'd0;
    localparam logic [SEV_W-1:0] SEV_HIGH = 2'd3;

    // Log entry is {anomaly_vec, severity, timestamp, last_bad_pc}, PC at bit 0.
    function automatic int log_pc_lsb();
        return 0;
    endfunction

    function automatic int log_ts_lsb(input int pc_w);
        return pc_w;
    endfunction

    function automatic int log_sev_lsb(input int pc_w, input int ts_w);
        return pc_w + ts_w;
    endfunction

    function automatic int log_av_lsb(input int pc_w, input int ts_w);
        return pc_w + ts_w + SEV_W;
    endfunction

    function automatic int log_width(input int pc_w, input int ts_w);
        return AV_W + SEV_W + ts_w + pc_w;
    endfunction

endpackage

// File: rtl/kavach_event_fifo.sv
// First-word-fall-through event log with full/empty flags.
// Pops on empty are ignored; a push while full succeeds only alongside a pop.
module kavach_event_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Head is masked so the output reads zero whenever the log is empty.
    assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/kavach_response_sequencer.sv
// Escalating anomaly response FSM with registered alert/halt/zeroize
// outputs and a timestamped event log of rising anomaly flags.
module kavach_response_sequencer
    import kavach_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int TS_WIDTH    = 16,
    parameter int LOG_DEPTH   = 8,
    parameter int CONFIRM_CYC = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           monitor_ready,
    input  logic [5:0]                     anomaly_vec,
    input  logic [1:0]                     severity,
    input  logic [PC_WIDTH-1:0]            last_bad_pc,
    input  logic                           host_ack,
    input  logic                           host_clear,
    input  logic                           log_rd_en,
    output logic                           irq_alert,
    output logic                           cpu_halt_req,
    output logic                           key_zeroize,
    output logic [2:0]                     state_o,
    output logic                           log_valid,
    output logic [8+TS_WIDTH+PC_WIDTH-1:0] log_data,
    output logic                           log_overflow
);

    localparam int LW     = log_width(PC_WIDTH, TS_WIDTH);
    localparam int PC_LSB = log_pc_lsb();
    localparam int TS_LSB = log_ts_lsb(PC_WIDTH);
    localparam int SV_LSB = log_sev_lsb(PC_WIDTH, TS_WIDTH);
    localparam int AV_LSB = log_av_lsb(PC_WIDTH, TS_WIDTH);
    localparam int CW     = $clog2(CONFIRM_CYC + 1);
    localparam int TW     = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CONFIRM_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [TW-1:0]       r_tmo;
    logic [TW-1:0]       w_tmo_nxt;
    logic                r_irq;
    logic                r_halt;
    logic                r_key;
    logic                r_lock_seen;
    logic                w_irq;
    logic                w_halt;
    logic                w_key;
    logic [TS_WIDTH-1:0] r_ts;
    logic [AV_W-1:0]     r_av_prev;
    logic                r_ovf;
    logic                w_sev_any;
    logic                w_sev_hi;
    logic                w_cnt_last;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_empty;
    logic                w_full;
    logic [LW-1:0]       w_entry;

    assign w_sev_any  = (severity != SEV_NONE);
    assign w_sev_hi   = (severity == SEV_HIGH);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (monitor_ready && w_sev_any) begin
                    w_state_nxt = ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (!w_sev_any) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sev_hi || w_cnt_last) begin
                    w_state_nxt = ST_ALERT;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_ALERT: begin
                w_tmo_nxt = r_tmo + TW'(1);
                if (host_ack) begin
                    w_state_nxt = ST_RECOVER;
                end else if (w_sev_hi || r_tmo == TMO_LAST) begin
                    w_state_nxt = ST_CONTAIN;
                end
            end
            ST_CONTAIN: begin
                if (w_sev_hi && w_cnt_last) begin
                    w_state_nxt = ST_LOCKDOWN;
                end else if (host_clear) begin
                    w_state_nxt = ST_RECOVER;
                end else if (w_sev_hi) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_LOCKDOWN: begin
                w_state_nxt = ST_LOCKDOWN;
            end
            ST_RECOVER: begin
                if (w_sev_hi) begin
                    w_state_nxt = ST_ALERT;
                end else if (w_sev_any) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Every state entry starts its persistence window from zero.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
            w_tmo_nxt = '0;
        end
    end

    always_comb begin
        w_irq  = 1'b0;
        w_halt = 1'b0;
        w_key  = 1'b0;
        unique case (r_state)
            ST_ALERT: begin
                w_irq = 1'b1;
            end
            ST_CONTAIN: begin
                w_irq  = 1'b1;
                w_halt = 1'b1;
            end
            ST_LOCKDOWN: begin
                w_irq  = 1'b1;
                w_halt = 1'b1;
                w_key  = !r_lock_seen;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq       <= 1'b0;
            r_halt      <= 1'b0;
            r_key       <= 1'b0;
            r_lock_seen <= 1'b0;
        end else begin
            r_irq       <= w_irq;
            r_halt      <= w_halt;
            r_key       <= w_key;
            r_lock_seen <= (r_state == ST_LOCKDOWN);
        end
    end

    assign irq_alert    = r_irq;
    assign cpu_halt_req = r_halt;
    assign key_zeroize  = r_key;
    assign state_o      = r_state;

    always_comb begin
        w_entry                       = '0;
        w_entry[PC_LSB +: PC_WIDTH]   = last_bad_pc;
        w_entry[TS_LSB +: TS_WIDTH]   = r_ts;
        w_entry[SV_LSB +: SEV_W]      = severity;
        w_entry[AV_LSB +: AV_W]       = anomaly_vec;
    end

    assign w_push = |(anomaly_vec & ~r_av_prev);
    assign w_pop  = log_rd_en && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts      <= '0;
            r_av_prev <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ts      <= r_ts + TS_WIDTH'(1);
            r_av_prev <= anomaly_vec;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (host_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    kavach_event_fifo #(
        .WIDTH (LW),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (log_rd_en),
        .o_data  (log_data),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign log_valid    = !w_empty;
    assign log_overflow = r_ovf;

endmodule

// File: tb/tb_kavach_response_sequencer.sv
// Directed bench: FSM escalation paths plus a scoreboard on the event log.
module tb_kavach_response_sequencer;

    localparam int PCW = 32;
    localparam int TSW = 16;
    localparam int LW  = 8 + TSW + PCW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           monitor_ready;
    logic [5:0]     anomaly_vec;
    logic [1:0]     severity;
    logic [PCW-1:0] last_bad_pc;
    logic           host_ack;
    logic           host_clear;
    logic           log_rd_en;
    logic           irq_alert;
    logic           cpu_halt_req;
    logic           key_zeroize;
    logic [2:0]     state_o;
    logic           log_valid;
    logic [LW-1:0]  log_data;
    logic           log_overflow;

    int             checks = 0;
    int             errors = 0;
    logic [LW-1:0]  sb [$];
    logic [TSW-1:0] tb_ts;
    logic           exp_ovf;
    int             rd_count = 0;
    logic           have_last;
    logic [TSW-1:0] last_ts;
    logic [5:0]     avt [9] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10,
                                6'h20, 6'h21, 6'h23, 6'h27};

    always #5 clk = ~clk;

    kavach_response_sequencer #(
        .PC_WIDTH    (PCW),
        .TS_WIDTH    (TSW),
        .LOG_DEPTH   (8),
        .CONFIRM_CYC (16),
        .ACK_TIMEOUT (1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .monitor_ready (monitor_ready),
        .anomaly_vec   (anomaly_vec),
        .severity      (severity),
        .last_bad_pc   (last_bad_pc),
        .host_ack      (host_ack),
        .host_clear    (host_clear),
        .log_rd_en     (log_rd_en),
        .irq_alert     (irq_alert),
        .cpu_halt_req  (cpu_halt_req),
        .key_zeroize   (key_zeroize),
        .state_o       (state_o),
        .log_valid     (log_valid),
        .log_data      (log_data),
        .log_overflow  (log_overflow)
    );

    // Free-running timestamp reference: counts clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + TSW'(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        monitor_ready = 1'b0;
        anomaly_vec   = '0;
        severity      = '0;
        last_bad_pc   = '0;
        host_ack      = 1'b0;
        host_clear    = 1'b0;
        log_rd_en     = 1'b0;
        sb.delete();
        exp_ovf       = 1'b0;
        have_last     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [5:0] av, input logic [1:0] sev,
                        input logic [PCW-1:0] pc, input logic rd,
                        input logic clr);
        logic [5:0] rise;
        logic       drop;
        rise = av & ~anomaly_vec;
        drop = 1'b0;
        anomaly_vec = av;
        severity    = sev;
        last_bad_pc = pc;
        log_rd_en   = rd;
        host_clear  = clr;
        if (rise != 6'd0) begin
            if (sb.size() < 8 || (rd && sb.size() > 0))
                sb.push_back({av, sev, tb_ts, pc});
            else
                drop = 1'b1;
        end
        if (drop)     exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        tick();
    endtask

    // Log monitor: each accepted pop is compared against the scoreboard head.
    initial begin
        logic [LW-1:0]  e;
        logic [TSW-1:0] ts;
        forever begin
            @(negedge clk);
            if (rst_n && log_rd_en && log_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL log_pop: got %0h required no entry", log_data);
                end else begin
                    e = sb.pop_front();
                    if (log_data !== e) begin
                        errors++;
                        $display("FAIL log_entry: got %0h required %0h", log_data, e);
                    end
                    rd_count++;
                    ts = log_data[PCW +: TSW];
                    if (have_last) begin
                        checks++;
                        if (ts <= last_ts) begin
                            errors++;
                            $display("FAIL log_ts_order: got %0h required > %0h", ts, last_ts);
                        end
                    end
                    last_ts   = ts;
                    have_last = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int kc;
        int n;
        int base;
        logic irq_seen;

        do_reset();
        chk("rst_state", state_o, 0);
        chk("rst_irq", irq_alert, 0);
        chk("rst_halt", cpu_halt_req, 0);
        chk("rst_key", key_zeroize, 0);
        chk("rst_valid", log_valid, 0);
        chk("rst_data", log_data, 0);
        chk("rst_ovf", log_overflow, 0);

        // Confirm after 16 persistent cycles, ack, quiet recovery with restart.
        monitor_ready = 1'b1;
        severity = 2'd1;
        tick();
        chk("A_confirm", state_o, 1);
        repeat (15) tick();
        chk("A_confirm_hold", state_o, 1);
        tick();
        chk("A_alert", state_o, 2);
        chk("A_irq_lag", irq_alert, 0);
        tick();
        chk("A_irq", irq_alert, 1);
        severity = 2'd0;
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        chk("A_recover", state_o, 5);
        tick();
        chk("A_irq_off", irq_alert, 0);
        repeat (7) tick();
        severity = 2'd1;
        tick();
        severity = 2'd0;
        repeat (15) tick();
        chk("A_recover_hold", state_o, 5);
        tick();
        chk("A_idle", state_o, 0);

        // Medium severity that fades before confirmation.
        irq_seen = 1'b0;
        severity = 2'd2;
        repeat (10) begin
            tick();
            irq_seen |= irq_alert;
        end
        chk("B_confirm", state_o, 1);
        severity = 2'd0;
        tick();
        chk("B_idle", state_o, 0);
        repeat (2) begin
            tick();
            irq_seen |= irq_alert;
        end
        chk("B_no_irq", irq_seen, 0);

        // High severity escalates to lockdown; clear loses to lockdown.
        severity = 2'd3;
        tick();
        chk("C_confirm", state_o, 1);
        tick();
        chk("C_alert", state_o, 2);
        tick();
        chk("C_contain", state_o, 3);
        chk("C_halt_lag", cpu_halt_req, 0);
        repeat (15) tick();
        chk("C_contain_hold", state_o, 3);
        chk("C_halt", cpu_halt_req, 1);
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        chk("C_lockdown", state_o, 4);
        chk("C_key_lag", key_zeroize, 0);
        kc = 0;
        repeat (10) begin
            tick();
            if (key_zeroize) kc++;
        end
        chk("C_key_once", kc, 1);
        severity = 2'd0;
        host_clear = 1'b1;
        repeat (3) tick();
        host_clear = 1'b0;
        chk("C_lock_stays", state_o, 4);
        chk("C_lock_halt", cpu_halt_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("C_async_halt", cpu_halt_req, 0);
        chk("C_async_state", state_o, 0);
        do_reset();

        // Unacknowledged alert times out into containment.
        monitor_ready = 1'b1;
        severity = 2'd3;
        tick();
        tick();
        chk("D_alert", state_o, 2);
        severity = 2'd1;
        repeat (1023) tick();
        chk("D_alert_hold", state_o, 2);
        tick();
        chk("D_contain", state_o, 3);
        tick();
        chk("D_halt", cpu_halt_req, 1);
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
        chk("D_recover", state_o, 5);
        tick();
        chk("D_halt_off", cpu_halt_req, 0);
        chk("D_irq_off", irq_alert, 0);

        // Ack beats simultaneous high severity; high severity re-alerts.
        do_reset();
        monitor_ready = 1'b1;
        severity = 2'd3;
        tick();
        tick();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        chk("E_ack_wins", state_o, 5);
        tick();
        chk("E_realert", state_o, 2);

        // Log fill: nine rising edges, eight kept, overflow sticky until clear.
        do_reset();
        for (int i = 0; i < 9; i++)
            step(avt[i], 2'(i), 32'h8000_0000 + 32'(i * 4), 1'b0, 1'b0);
        chk("F_state_idle", state_o, 0);
        chk("F_valid", log_valid, 1);
        chk("F_ovf", log_overflow, exp_ovf);
        step(6'h27, 2'd0, '0, 1'b0, 1'b1);
        chk("F_ovf_clear", log_overflow, exp_ovf);

        // Push and pop on a full log, then drain and reuse.
        step(6'h2F, 2'd2, 32'hCAFE_0000, 1'b1, 1'b0);
        chk("G_no_ovf", log_overflow, exp_ovf);
        base = rd_count;
        n = 0;
        while (log_valid && n < 20) begin
            step(6'h2F, 2'd0, '0, 1'b1, 1'b0);
            n++;
        end
        chk("G_count", rd_count - base, 8);
        chk("G_sb_empty", sb.size(), 0);
        chk("G_empty", log_valid, 0);
        chk("G_empty_data", log_data, 0);
        step(6'h2F, 2'd0, '0, 1'b1, 1'b0);
        chk("G_empty_pop", log_valid, 0);
        step(6'h3F, 2'd1, 32'h1234_5678, 1'b0, 1'b0);
        chk("G_refill", log_valid, 1);
        step(6'h3F, 2'd0, '0, 1'b1, 1'b0);
        log_rd_en = 1'b0;
        chk("G_drained", log_valid, 0);
        chk("G_sb_done", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
